// File: rtl/buffer_ram_responder_if.sv
// Handshake bundle for buffer_ram_responder: read/write/clear requests in,
// read data and clear status out.
interface buffer_ram_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 512
);
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic              wren;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              clear_start;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              busy;
  logic              clear_done;
  logic              wr_drop;

  modport master (
    output ren, raddr, wren, waddr, wdata, clear_start,
    input  rdata, rdata_valid, busy, clear_done, wr_drop
  );

  modport slave (
    input  ren, raddr, wren, waddr, wdata, clear_start,
    output rdata, rdata_valid, busy, clear_done, wr_drop
  );
endinterface

// File: rtl/buffer_ram_responder.sv
// Word buffer with fixed-latency pipelined reads, write-first bypass and a
// background zero-fill engine that locks out external writes while it runs.
module buffer_ram_responder #(
  parameter int          ADDR_W = 10,
  parameter int          DATA_W = 512,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  buffer_ram_responder_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clear_we;
  logic              ext_we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] d_pipe [RD_LAT];
  logic [RD_LAT-1:0] v_pipe;

  assign clear_we = (state == CLEAR);
  assign ext_we   = bus.wren && !bus.busy;

  // Write-first: a read colliding with this edge's write sees the new word.
  always_comb begin
    rd_word = mem[bus.raddr];
    if (clear_we && (clr_addr == bus.raddr))
      rd_word = '0;
    else if (ext_we && (bus.waddr == bus.raddr))
      rd_word = bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (clear_we)
      mem[clr_addr] <= '0;
    else if (ext_we)
      mem[bus.waddr] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    d_pipe[0] <= rd_word;
    for (int unsigned i = 1; i < RD_LAT; i++)
      d_pipe[i] <= d_pipe[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe          <= '0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
    end else begin
      v_pipe[0] <= bus.ren;
      for (int unsigned i = 1; i < RD_LAT; i++)
        v_pipe[i] <= v_pipe[i-1];
      if (v_pipe[RD_LAT-1])
        bus.rdata <= d_pipe[RD_LAT-1];
      bus.rdata_valid <= v_pipe[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      clr_addr       <= '0;
      bus.busy       <= 1'b0;
      bus.clear_done <= 1'b0;
      bus.wr_drop    <= 1'b0;
    end else begin
      bus.clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear_start) begin
            state       <= CLEAR;
            clr_addr    <= '0;
            bus.busy    <= 1'b1;
            bus.wr_drop <= 1'b0;
          end
        end
        CLEAR: begin
          if (bus.wren)
            bus.wr_drop <= 1'b1;
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
